// File: rtl/sar_search.sv
// Successive-approximation search: recovers an unknown value A one bit per
// clock (MSB first) by driving trial values B into an external A>B comparator.
module sar_search #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             AgtB,
  output logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    idx_d    = idx_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          r_d     = '0;
          idx_d   = IW'(WIDTH - 1);
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (AgtB) r_d[idx_q] = 1'b1;
          // The final edge captures R including the bit decided on this edge.
          if (idx_q == '0) begin
            result_d = r_d;
            state_d  = S_DONE;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // B depends only on registered state, so AgtB never loops back into B.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      mask[i] = (i < 32'(idx_q));
    end
    B      = '0;
    busy   = 1'b0;
    done   = 1'b0;
    result = result_q;
    unique case (state_q)
      S_SEARCH: begin
        B    = r_q | mask;
        busy = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
